// File: rtl/add32_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : add32_acc_if
// Brief    : Operand stream and result handshake bundle for add32_acc.
//            ADD32_ACC_SUB_EN adds the per-beat in_sub qualifier.
// Revision : 1.0 - initial release
// ============================================================================
interface add32_acc_if #(
    parameter int COUNT_W = 8
);
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
`ifdef ADD32_ACC_SUB_EN
    logic               in_sub;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_sum;
    logic               out_c;
    logic               out_flower;
    logic [COUNT_W-1:0] out_count;

    modport master (
`ifdef ADD32_ACC_SUB_EN
        output in_sub,
`endif
        output start, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_c, out_flower, out_count
    );

    modport slave (
`ifdef ADD32_ACC_SUB_EN
        input  in_sub,
`endif
        input  start, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_c, out_flower, out_count
    );
endinterface
`default_nettype wire

// File: rtl/add32_acc.sv
`default_nettype none
// ============================================================================
// Module   : add32_acc
// Brief    : Packet accumulator with sticky carry/overflow and saturating
//            beat count. Define ADD32_ACC_SUB_EN for per-beat subtraction.
// Revision : 1.0 - initial release
// ============================================================================
module add32_acc #(
    parameter int COUNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    add32_acc_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] c_count_max = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_fire;
    logic               w_clear;
    logic               w_sub;
    logic [31:0]        w_operand;
    logic [32:0]        w_sum33;
    logic               w_ovf;
    logic [31:0]        r_acc;
    logic               r_c;
    logic               r_flower;
    logic [COUNT_W-1:0] r_count;

`ifdef ADD32_ACC_SUB_EN
    assign w_sub = bus.in_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction reuses the adder as acc + ~in_data + 1.
    assign w_operand = w_sub ? ~bus.in_data : bus.in_data;
    assign w_sum33   = {1'b0, r_acc} + {1'b0, w_operand} + {32'd0, w_sub};
    assign w_ovf     = (r_acc[31] == w_operand[31]) && (w_sum33[31] != r_acc[31]);

    assign w_fire  = w_in_ready && bus.in_valid;
    assign w_clear = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_ACC;
                end
            end
            S_ACC: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= 32'd0;
            r_c      <= 1'b0;
            r_flower <= 1'b0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_acc    <= 32'd0;
            r_c      <= 1'b0;
            r_flower <= 1'b0;
            r_count  <= '0;
        end else if (w_fire) begin
            r_acc    <= w_sum33[31:0];
            r_c      <= r_c | w_sum33[32];
            r_flower <= r_flower | w_ovf;
            if (r_count != c_count_max) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Results stay on the port after DONE until the next start clears them.
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_sum    = r_acc;
    assign bus.out_c      = r_c;
    assign bus.out_flower = r_flower;
    assign bus.out_count  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_add32_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_add32_acc
// Brief    : Randomized self-checking bench for add32_acc against an
//            arithmetic packet model. Honours ADD32_ACC_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add32_acc;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    add32_acc_if #(.COUNT_W(8)) ifa ();
    add32_acc_if #(.COUNT_W(2)) ifb ();

    add32_acc #(.COUNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    add32_acc #(.COUNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] q_data[$];
    bit          q_sub[$];
    logic [31:0] exp_sum;
    bit          exp_c;
    bit          exp_v;
    int          exp_cnt;

    // Packet result from plain signed/unsigned arithmetic on the beat list.
    task automatic model_packet(input int count_w);
        logic [31:0]     acc32;
        longint unsigned ua;
        longint unsigned ux;
        longint signed   sa;
        longint signed   sx;
        longint signed   sr;
        bit              sub;
        int              max_cnt;
        acc32 = 32'd0;
        exp_c = 1'b0;
        exp_v = 1'b0;
        for (int i = 0; i < q_data.size(); i++) begin
            sub = (i < q_sub.size()) ? q_sub[i] : 1'b0;
            ua  = acc32;
            ux  = q_data[i];
            sa  = $signed(acc32);
            sx  = $signed(q_data[i]);
            sr  = sub ? (sa - sx) : (sa + sx);
            if (sr > 64'sd2147483647 || sr < -64'sd2147483648) exp_v = 1'b1;
            if (sub ? (ua >= ux) : ((ua + ux) > 64'hFFFF_FFFF)) exp_c = 1'b1;
            acc32 = sub ? (acc32 - q_data[i]) : (acc32 + q_data[i]);
        end
        exp_sum = acc32;
        max_cnt = (1 << count_w) - 1;
        exp_cnt = (q_data.size() > max_cnt) ? max_cnt : q_data.size();
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    // Full packet on dut_a: start, beats, result check, hold/backpressure, release.
    task automatic run_packet_a(input string tag, input bit gaps, input int hold,
                                input bit poke, input bit quick);
        int waited;
        model_packet(8);
        if (!quick) begin
            @(posedge clk); #1;
        end
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        checks++;
        if (ifa.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s start_to_ready: in_ready=%b want 1", tag, ifa.in_ready);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ifa.in_valid = 1'b1;
            ifa.in_data  = q_data[i];
            ifa.in_last  = (i == q_data.size() - 1);
`ifdef ADD32_ACC_SUB_EN
            ifa.in_sub   = (i < q_sub.size()) ? q_sub[i] : 1'b0;
`endif
            if (poke && i == 1) ifa.start = 1'b1;
            @(negedge clk);
            checks++;
            if ({ifa.in_ready, ifa.out_valid} !== 2'b10) begin
                failures++;
                $display("FAIL %s beat%0d_ready: in_ready/out_valid=%b%b want 10",
                         tag, i, ifa.in_ready, ifa.out_valid);
            end
            waited = 0;
            while (ifa.in_ready !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            @(posedge clk); #1;
            ifa.in_valid = 1'b0;
            ifa.in_last  = 1'b0;
            ifa.start    = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({ifa.out_valid, ifa.in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL %s done_flags: out_valid/in_ready=%b%b want 10",
                     tag, ifa.out_valid, ifa.in_ready);
        end
        checks++;
        if (ifa.out_sum !== exp_sum) begin
            failures++;
            $display("FAIL %s sum: got %h want %h", tag, ifa.out_sum, exp_sum);
        end
        checks++;
        if ({ifa.out_c, ifa.out_flower} !== {exp_c, exp_v}) begin
            failures++;
            $display("FAIL %s c/flower: got %b%b want %b%b", tag,
                     ifa.out_c, ifa.out_flower, exp_c, exp_v);
        end
        checks++;
        if (ifa.out_count !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL %s count: got %0d want %0d", tag, ifa.out_count, exp_cnt);
        end
        for (int k = 0; k < hold; k++) begin
            ifa.start = (k == 1);
            @(negedge clk);
            checks++;
            if ({ifa.out_valid, ifa.in_ready, ifa.out_sum, ifa.out_c, ifa.out_flower}
                !== {2'b10, exp_sum, exp_c, exp_v}) begin
                failures++;
                $display("FAIL %s hold%0d: valid/ready=%b%b sum=%h want 10 sum=%h",
                         tag, k, ifa.out_valid, ifa.in_ready, ifa.out_sum, exp_sum);
            end
        end
        ifa.start     = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.out_valid, ifa.in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL %s release: out_valid/in_ready=%b%b want 00",
                     tag, ifa.out_valid, ifa.in_ready);
        end
        checks++;
        if (ifa.out_sum !== exp_sum) begin
            failures++;
            $display("FAIL %s kept_sum: got %h want %h", tag, ifa.out_sum, exp_sum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready: got %b want 0", ifa.in_ready); end
        checks++;
        if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %b want 0", ifa.out_valid); end
        checks++;
        if (ifa.out_sum !== 32'd0) begin failures++; $display("FAIL reset out_sum: got %h want 0", ifa.out_sum); end
        checks++;
        if ({ifa.out_c, ifa.out_flower} !== 2'b00) begin
            failures++;
            $display("FAIL reset flags: got %b%b want 00", ifa.out_c, ifa.out_flower);
        end
        checks++;
        if (ifa.out_count !== 8'd0) begin failures++; $display("FAIL reset out_count: got %0d want 0", ifa.out_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ifa.in_ready, ifa.out_valid, ifb.in_ready, ifb.out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset idle: a=%b%b b=%b%b want 0000",
                     ifa.in_ready, ifa.out_valid, ifb.in_ready, ifb.out_valid);
        end
    endtask

    task automatic test_directed();
        q_sub.delete();
        q_data = '{32'd1, 32'd2, 32'd3};
        run_packet_a("sum123", 1'b0, 0, 1'b0, 1'b0);
        q_data = '{32'hFFFF_FFFF, 32'h0000_0001};
        run_packet_a("carry", 1'b0, 0, 1'b0, 1'b0);
        q_data = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        run_packet_a("ovf_sticky", 1'b0, 0, 1'b0, 1'b0);
        q_data = '{32'h8000_0000};
        run_packet_a("one_beat", 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        q_sub.delete();
        q_data = '{32'h1234_5678, 32'h8765_4321, 32'hF000_000F};
        run_packet_a("backpressure", 1'b0, 5, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        q_sub.delete();
        for (int p = 0; p < 4; p++) begin
            q_data.delete();
            repeat ($urandom_range(1, 6)) q_data.push_back(rand_word());
            run_packet_a("b2b", 1'b0, 0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            q_data.delete();
            q_sub.delete();
            repeat ($urandom_range(1, 8)) begin
                q_data.push_back(rand_word());
`ifdef ADD32_ACC_SUB_EN
                q_sub.push_back(1'($urandom_range(0, 1)));
`endif
            end
            run_packet_a("random", 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_count_sat();
        q_sub.delete();
        q_data = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        model_packet(2);
        @(posedge clk); #1;
        ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = q_data[i];
            ifb.in_last  = (i == 4);
            @(posedge clk); #1;
        end
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (ifb.out_valid !== 1'b1) begin failures++; $display("FAIL sat valid: got %b want 1", ifb.out_valid); end
        checks++;
        if (ifb.out_sum !== exp_sum) begin failures++; $display("FAIL sat sum: got %h want %h", ifb.out_sum, exp_sum); end
        checks++;
        if (ifb.out_count !== 2'(exp_cnt)) begin
            failures++;
            $display("FAIL sat count: got %0d want %0d", ifb.out_count, exp_cnt);
        end
        ifb.out_ready = 1'b1;
        @(posedge clk); #1;
        ifb.out_ready = 1'b0;
        checks++;
        if (ifb.out_valid !== 1'b0) begin failures++; $display("FAIL sat release: got %b want 0", ifb.out_valid); end
    endtask

    task automatic test_reset_mid();
        q_sub.delete();
        q_data = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        model_packet(8);
        @(posedge clk); #1;
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = q_data[i];
            ifa.in_last  = 1'b0;
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.out_sum, ifa.out_c, ifa.out_count} !== {exp_sum, exp_c, 8'(exp_cnt)}) begin
            failures++;
            $display("FAIL midrst pre: sum=%h c=%b cnt=%0d want %h %b %0d",
                     ifa.out_sum, ifa.out_c, ifa.out_count, exp_sum, exp_c, exp_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.in_ready, ifa.out_valid, ifa.out_sum, ifa.out_c, ifa.out_flower, ifa.out_count} !== 44'd0) begin
            failures++;
            $display("FAIL midrst clear: ready=%b sum=%h c=%b f=%b cnt=%0d want all 0",
                     ifa.in_ready, ifa.out_sum, ifa.out_c, ifa.out_flower, ifa.out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ifa.in_ready, ifa.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL midrst idle: in_ready/out_valid=%b%b want 00", ifa.in_ready, ifa.out_valid);
        end
    endtask

`ifdef ADD32_ACC_SUB_EN
    task automatic test_sub();
        q_data = '{32'd5, 32'd7};
        q_sub  = '{1'b0, 1'b1};
        run_packet_a("sub_5m7", 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (ifa.out_sum !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL sub_5m7 literal: got %h want fffffffe", ifa.out_sum);
        end
        q_data = '{32'h8000_0000, 32'd1};
        q_sub  = '{1'b0, 1'b1};
        run_packet_a("sub_ovf", 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (ifa.out_flower !== 1'b1) begin
            failures++;
            $display("FAIL sub_ovf literal: got %b want 1", ifa.out_flower);
        end
    endtask
`endif

    initial begin
        ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = 32'd0; ifa.in_last = 1'b0; ifa.out_ready = 1'b0;
        ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = 32'd0; ifb.in_last = 1'b0; ifb.out_ready = 1'b0;
`ifdef ADD32_ACC_SUB_EN
        ifa.in_sub = 1'b0;
        ifb.in_sub = 1'b0;
`endif
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_count_sat();
        test_reset_mid();
`ifdef ADD32_ACC_SUB_EN
        test_sub();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
